key_step_ctrl: RTL and testbench

//  Input-side front end for the board LED counter. Conditions two raw

---
 rtl/key_step_ctrl_pkg.sv | 21 ++
 rtl/key_debounce.sv | 96 +++++++++
 rtl/key_step_ctrl.sv | 101 ++++++++++
 tb/tb_key_step_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_step_ctrl_pkg.sv
// Shared definitions for the key step controller: debounce state encodings,
// default timing constants and a counter-width helper.
package key_step_ctrl_pkg;

  // Debounce FSM state encodings
  localparam logic [1:0] KEY_IDLE         = 2'd0;
  localparam logic [1:0] KEY_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] KEY_PRESSED      = 2'd2;
  localparam logic [1:0] KEY_RELEASE_WAIT = 2'd3;

  // Default timing, 50 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, debounce FSM and a saturating
// stability counter. Reports the debounced level, a "still pressed" flag
// (PRESSED with the key still down this cycle) and a one-cycle accept pulse
// on the PRESS_WAIT -> PRESSED transition.
//
//  state         | meaning
//  KEY_IDLE      | key released and stable
//  PRESS_WAIT    | key went down, waiting for it to stay down
//  PRESSED       | press accepted, key held
//  RELEASE_WAIT  | key went up, waiting for it to stay up
module key_debounce
  import key_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic held_o,
  output logic accept_o
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_low;
  logic             accept_d;

  assign key_low = ~sync_q[1];

  // Two-stage synchroniser; idles at the released (high) level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n_i};
  end

  // Debounce next-state; counter only advances in the wait states and stops at CNT_LAST
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    case (state_q)
      KEY_IDLE: begin
        if (key_low) begin
          state_d = KEY_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      KEY_PRESS_WAIT: begin
        if (!key_low) begin
          state_d = KEY_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = KEY_PRESSED;
          accept_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KEY_PRESSED: begin
        if (!key_low) begin
          state_d = KEY_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (key_low) begin
          state_d = KEY_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KEY_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o  = (state_q == KEY_PRESSED) || (state_q == KEY_RELEASE_WAIT);
  assign held_o   = (state_q == KEY_PRESSED) && key_low;
  assign accept_o = accept_d;

endmodule

// File: rtl/key_step_ctrl.sv
// Key front end for the board LED counter. key[0] press -> one-cycle step,
// key[1] press -> direction toggle. When both presses land together the
// step sees the new direction because both registers update on one edge.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat steps while key[0] held).
module key_step_ctrl
  import key_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key,
  output logic       step,
  output logic       up_down,
  output logic [1:0] key_state
);

  logic [1:0] accept;
  logic [1:0] key_held;
  logic       rpt_fire;
  logic       step_q, step_d;
  logic       up_down_q, up_down_d;
  logic       unused_key1_held;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk      (clk),
    .reset    (reset),
    .key_n_i  (key[0]),
    .level_o  (key_state[0]),
    .held_o   (key_held[0]),
    .accept_o (accept[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk      (clk),
    .reset    (reset),
    .key_n_i  (key[1]),
    .level_o  (key_state[1]),
    .held_o   (key_held[1]),
    .accept_o (accept[1])
  );

  assign unused_key1_held = key_held[1];

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = cnt_width(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // Hold timer: first fire after REPEAT_DELAY held cycles, then reload so the
  // next fire comes REPEAT_PERIOD cycles later; any break in the hold clears it
  always_comb begin
    rpt_fire  = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    if (!key_held[0]) begin
      rpt_cnt_d = '0;
    end else if (rpt_cnt_q == RPT_FIRST) begin
      rpt_fire  = 1'b1;
      rpt_cnt_d = RPT_RELOAD;
    end else begin
      rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
    end
  end

  // Repeat timer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rpt_cnt_q <= '0;
    else        rpt_cnt_q <= rpt_cnt_d;
  end
`else
  logic unused_repeat;

  assign rpt_fire      = 1'b0;
  assign unused_repeat = ^{key_held[0], REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  // Step and direction next values
  always_comb begin
    step_d    = accept[0] | rpt_fire;
    up_down_d = up_down_q ^ accept[1];
  end

  // Step pulse and direction level registers; count up out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q    <= 1'b0;
      up_down_q <= 1'b1;
    end else begin
      step_q    <= step_d;
      up_down_q <= up_down_d;
    end
  end

  assign step    = step_q;
  assign up_down = up_down_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
module tb_key_step_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] key = 2'b11;
  logic       step;
  logic       up_down;
  logic [1:0] key_state;

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .step      (step),
    .up_down   (up_down),
    .key_state (key_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: debounced level flips once the synchronised key has
  // disagreed with it on D+1 consecutive edges
  logic [1:0] sq[$];
  logic [1:0] lvl;
  int         run0, run1;
  logic       m_step, m_dir;
  int         held;
  logic       was_in;
  int         cyc = 0;
  int         win_start = 0;
  logic       prev_step = 1'b0;
  int         steps_q[$];
  int         exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq = '{2'b11, 2'b11};
    lvl = 2'b00; run0 = 0; run1 = 0;
    m_step = 1'b0; m_dir = 1'b1;
    held = 0; was_in = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] s;
    logic [1:0] acc;
    logic       in_p;
    s = sq.pop_front();
    sq.push_back(key);
    acc = 2'b00;
    if (!s[0] != lvl[0]) run0++; else run0 = 0;
    if (run0 == D + 1) begin lvl[0] = ~lvl[0]; run0 = 0; acc[0] = lvl[0]; end
    if (!s[1] != lvl[1]) run1++; else run1 = 0;
    if (run1 == D + 1) begin lvl[1] = ~lvl[1]; run1 = 0; acc[1] = lvl[1]; end
    m_dir  = m_dir ^ acc[1];
    m_step = acc[0];
`ifdef AUTO_REPEAT_EN
    in_p = lvl[0] && (run0 == 0);
    if (in_p && !was_in) held = 0;
    else if (in_p) begin
      held++;
      if (held >= RD && ((held - RD) % RP) == 0) m_step = 1'b1;
    end
    was_in = in_p;
`else
    in_p = 1'b0;
    was_in = in_p;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    cyc++;
    #1;
    chk("step", step, m_step);
    chk("up_down", up_down, m_dir);
    chk("key_state", key_state, lvl);
    chk("step_consecutive", step & prev_step, 0);
    prev_step = step;
    if (step === 1'b1) steps_q.push_back(cyc - win_start);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic open_window();
    win_start = cyc;
    steps_q.delete();
  endtask

  task automatic chk_steps(input string tag);
    chk({tag, "_count"}, steps_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < steps_q.size(); i++)
      chk({tag, "_cycle"}, steps_q[i], exp_q[i]);
  endtask

  initial begin
    model_reset();

    // 1 reset
    reset = 1'b0; key = 2'b11;
    ticks(3);
    chk("rst_step", step, 0);
    chk("rst_up_down", up_down, 1);
    chk("rst_key_state", key_state, 0);
    reset = 1'b1;
    ticks(3);

    // 2 clean press held 20 cycles
    open_window();
    key = 2'b10;
    ticks(20);
    chk("press_key_state", key_state, 2'b01);
`ifdef AUTO_REPEAT_EN
    exp_q = '{7, 17, 20};
`else
    exp_q = '{7};
`endif
    chk_steps("clean_press");
    key = 2'b11;
    ticks(10);
    chk("release_key_state", key_state, 2'b00);

    // 3 bounce
    open_window();
    key = 2'b10; ticks(2);
    key = 2'b11; ticks(1);
    key = 2'b10; ticks(2);
    key = 2'b11; ticks(10);
    exp_q.delete();
    chk_steps("bounce");
    chk("bounce_key_state", key_state, 2'b00);

    // 4 direction toggles
    open_window();
    key = 2'b01; ticks(8);
    chk("dir_first", up_down, 0);
    key = 2'b11; ticks(8);
    key = 2'b01; ticks(8);
    chk("dir_second", up_down, 1);
    key = 2'b11; ticks(8);
    chk_steps("dir_no_step");

    // 5 simultaneous press
    key = 2'b00;
    ticks(6);
    chk("simul_pre_step", step, 0);
    chk("simul_pre_dir", up_down, 1);
    tick();
    chk("simul_step", step, 1);
    chk("simul_dir", up_down, 0);
    chk("simul_key_state", key_state, 2'b11);
    key = 2'b11;
    ticks(10);

    // 6 reset during PRESS_WAIT with key held through
    key = 2'b10;
    ticks(3);
    open_window();
    reset = 1'b0;
    ticks(3);
    exp_q.delete();
    chk_steps("reset_hold");
    reset = 1'b1;
    open_window();
    ticks(24);
`ifdef AUTO_REPEAT_EN
    exp_q = '{7, 17, 20, 23};
`else
    exp_q = '{7};
`endif
    chk_steps("after_reset");
    key = 2'b11;
    ticks(10);

    // randomized key activity with occasional resets
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        ticks($urandom_range(1, 3));
        reset = 1'b1;
      end
      key = 2'($urandom_range(0, 3));
      ticks($urandom_range(1, 9));
    end
    key = 2'b11;
    ticks(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
